// File: rtl/st7789_spi_rx_if.sv
// st7789_spi_rx_if
//   Bundles the ST7789 serial pins and the decoded panel-side outputs of
//   st7789_spi_rx into one interface.
//   Signals:
//     st7789_SCL/SDA/DC : serial link from the transmitter (SCL idles high)
//     w_we              : pixel write strobe, one cycle per pixel
//     w_waddr           : write address {y, x}
//     w_wdata           : RGB565 pixel
//     w_frame_done      : pulses with the write at (XE, YE)
//     w_disp_on/w_inv_on: display-on / inversion status
//     w_madctl/w_colmod : last MADCTL / COLMOD parameter
//   Modports:
//     master : the transmitter side (drives the pins, observes outputs)
//     slave  : the receiver side (st7789_spi_rx)
interface st7789_spi_rx_if;
  logic        st7789_SCL;
  logic        st7789_SDA;
  logic        st7789_DC;
  logic        w_we;
  logic [15:0] w_waddr;
  logic [15:0] w_wdata;
  logic        w_frame_done;
  logic        w_disp_on;
  logic        w_inv_on;
  logic [7:0]  w_madctl;
  logic [7:0]  w_colmod;

  modport master (
    output st7789_SCL, st7789_SDA, st7789_DC,
    input  w_we, w_waddr, w_wdata, w_frame_done,
    input  w_disp_on, w_inv_on, w_madctl, w_colmod
  );

  modport slave (
    input  st7789_SCL, st7789_SDA, st7789_DC,
    output w_we, w_waddr, w_wdata, w_frame_done,
    output w_disp_on, w_inv_on, w_madctl, w_colmod
  );
endinterface

// File: rtl/st7789_spi_rx.sv
// st7789_spi_rx
//   Panel-side model of the ST7789 write-only 3-wire link. Recovers 9-bit
//   transfers (DC + 8 data bits, MSB first, sampled on SCL falling edges),
//   decodes the command set used by the display driver and emits RGB565
//   pixel writes into a 256x256 frame memory addressed as {y, x}.
//   Parameters:
//     SYNC_STAGES : flops on SCL/SDA/DC before edge detection (0..3)
//     IDLE_CYC    : cycles without a falling edge before a partial byte is dropped
//   Ports:
//     w_clk   : single clock, all logic in this domain
//     w_rst_n : asynchronous active-low reset
//     bus     : st7789_spi_rx_if.slave (serial pins in, decoded outputs out)
module st7789_spi_rx #(
  parameter int SYNC_STAGES = 0,
  parameter int IDLE_CYC    = 64
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  st7789_spi_rx_if.slave    bus
);

  localparam int              IW        = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [IW-1:0]   IDLE_LAST = IW'(IDLE_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PARAM, ST_RAMWR} state_t;
  typedef enum logic [1:0] {TG_CASET, TG_RASET, TG_MADCTL, TG_COLMOD} tgt_t;

  // Whole decoder state including registered outputs; a single reset
  // constant serves both the pin reset and SWRESET.
  typedef struct packed {
    state_t      state;
    tgt_t        tgt;
    logic [1:0]  pidx;
    logic        phase;       // 1 = high byte of the current pixel held
    logic [7:0]  hi;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  xs;
    logic [7:0]  xe;
    logic [7:0]  ys;
    logic [7:0]  ye;
    logic        we;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        frame_done;
    logic        disp_on;
    logic        inv_on;
    logic [7:0]  madctl;
    logic [7:0]  colmod;
  } dec_t;

  localparam dec_t DEC_RST = '{
    state: ST_IDLE, tgt: TG_CASET, pidx: 2'd0, phase: 1'b0, hi: 8'd0,
    x: 8'd0, y: 8'd0, xs: 8'd0, xe: 8'd239, ys: 8'd0, ye: 8'd239,
    we: 1'b0, waddr: 16'd0, wdata: 16'd0, frame_done: 1'b0,
    disp_on: 1'b0, inv_on: 1'b0, madctl: 8'd0, colmod: 8'd0
  };

  // ---------------------------------------------------------------------
  // Input path: optional synchroniser chain, stage 0 is the raw pins.
  // Bit order within each stage is {SCL, SDA, DC}.
  // ---------------------------------------------------------------------
  logic [2:0] pipe_s [0:SYNC_STAGES];
  assign pipe_s[0] = {bus.st7789_SCL, bus.st7789_SDA, bus.st7789_DC};

  for (genvar g = 1; g <= SYNC_STAGES; g++) begin : g_sync
    logic [2:0] stg_r;
    // Synchroniser stage; resets to the idle-high line state.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
        stg_r <= 3'b111;
      end else begin
        stg_r <= pipe_s[g-1];
      end
    end
    assign pipe_s[g] = stg_r;
  end

  logic scl_s;
  logic sda_s;
  logic dc_s;
  assign scl_s = pipe_s[SYNC_STAGES][2];
  assign sda_s = pipe_s[SYNC_STAGES][1];
  assign dc_s  = pipe_s[SYNC_STAGES][0];

  logic          scl_prev_r;
  logic [2:0]    bitcnt_r;
  logic [6:0]    sh_r;
  logic [IW-1:0] idle_cnt_r;

  logic       fall_s;
  logic       byte_vld_s;
  logic [7:0] byte_s;
  logic       cmd_s;
  logic       swreset_s;

  assign fall_s     = scl_prev_r & ~scl_s;
  assign byte_vld_s = fall_s & (bitcnt_r == 3'd7);
  assign byte_s     = {sh_r, sda_s};
  assign cmd_s      = byte_vld_s & ~dc_s;
  assign swreset_s  = cmd_s & (byte_s == 8'h01);

  // Edge detector, bit shifter and idle resync counter.
  // A falling edge in the timeout cycle takes priority and starts a new count.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      scl_prev_r <= 1'b1;
      bitcnt_r   <= 3'd0;
      sh_r       <= 7'd0;
      idle_cnt_r <= '0;
    end else begin
      scl_prev_r <= scl_s;
      if (fall_s) begin
        idle_cnt_r <= '0;
        sh_r       <= {sh_r[5:0], sda_s};
        bitcnt_r   <= (bitcnt_r == 3'd7) ? 3'd0 : bitcnt_r + 3'd1;
      end else if (bitcnt_r != 3'd0) begin
        if (idle_cnt_r == IDLE_LAST) begin
          bitcnt_r   <= 3'd0;
          idle_cnt_r <= '0;
        end else begin
          idle_cnt_r <= idle_cnt_r + IW'(1);
        end
      end else begin
        idle_cnt_r <= '0;
      end
    end
  end

  dec_t d_r;

  // Command decoder FSM with registered outputs; acts in the cycle the
  // byte completes so all effects appear one cycle later.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      d_r <= DEC_RST;
    end else if (swreset_s) begin
      d_r <= DEC_RST;
    end else begin
      d_r.we         <= 1'b0;
      d_r.frame_done <= 1'b0;
      if (cmd_s) begin
        // Any command aborts whatever was in progress.
        d_r.pidx  <= 2'd0;
        d_r.phase <= 1'b0;
        d_r.state <= ST_IDLE;
        case (byte_s)
          8'h2A: begin d_r.state <= ST_PARAM; d_r.tgt <= TG_CASET;  end
          8'h2B: begin d_r.state <= ST_PARAM; d_r.tgt <= TG_RASET;  end
          8'h36: begin d_r.state <= ST_PARAM; d_r.tgt <= TG_MADCTL; end
          8'h3A: begin d_r.state <= ST_PARAM; d_r.tgt <= TG_COLMOD; end
          8'h2C: begin
            d_r.state <= ST_RAMWR;
            d_r.x     <= d_r.xs;
            d_r.y     <= d_r.ys;
          end
          8'h21:   d_r.inv_on  <= 1'b1;
          8'h20:   d_r.inv_on  <= 1'b0;
          8'h29:   d_r.disp_on <= 1'b1;
          8'h28:   d_r.disp_on <= 1'b0;
          default: d_r.state   <= ST_IDLE;
        endcase
      end else if (byte_vld_s) begin
        case (d_r.state)
          ST_PARAM: begin
            case (d_r.tgt)
              TG_CASET, TG_RASET: begin
                // Only the low bytes matter in a 256x256 memory.
                case (d_r.pidx)
                  2'd1: begin
                    if (d_r.tgt == TG_CASET) d_r.xs <= byte_s;
                    else                     d_r.ys <= byte_s;
                  end
                  2'd3: begin
                    if (d_r.tgt == TG_CASET) d_r.xe <= byte_s;
                    else                     d_r.ye <= byte_s;
                    d_r.state <= ST_IDLE;
                  end
                  default: ;
                endcase
                d_r.pidx <= d_r.pidx + 2'd1;
              end
              TG_MADCTL: begin
                d_r.madctl <= byte_s;
                d_r.state  <= ST_IDLE;
              end
              default: begin
                d_r.colmod <= byte_s;
                d_r.state  <= ST_IDLE;
              end
            endcase
          end
          ST_RAMWR: begin
            if (!d_r.phase) begin
              d_r.hi    <= byte_s;
              d_r.phase <= 1'b1;
            end else begin
              d_r.phase      <= 1'b0;
              d_r.we         <= 1'b1;
              d_r.waddr      <= {d_r.y, d_r.x};
              d_r.wdata      <= {d_r.hi, byte_s};
              d_r.frame_done <= (d_r.x == d_r.xe) && (d_r.y == d_r.ye);
              // Raster advance inside the window, 8-bit wrap outside it.
              if (d_r.x == d_r.xe) begin
                d_r.x <= d_r.xs;
                d_r.y <= (d_r.y == d_r.ye) ? d_r.ys : d_r.y + 8'd1;
              end else begin
                d_r.x <= d_r.x + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.w_we         = d_r.we;
  assign bus.w_waddr      = d_r.waddr;
  assign bus.w_wdata      = d_r.wdata;
  assign bus.w_frame_done = d_r.frame_done;
  assign bus.w_disp_on    = d_r.disp_on;
  assign bus.w_inv_on     = d_r.inv_on;
  assign bus.w_madctl     = d_r.madctl;
  assign bus.w_colmod     = d_r.colmod;

endmodule

// File: tb/tb_st7789_spi_rx.sv
// tb_st7789_spi_rx
//   Randomised and directed bench for st7789_spi_rx. A reference model
//   (window arithmetic on a pixel counter) predicts every pixel write into a
//   queue; a monitor on the opposite clock edge pops and compares.
module tb_st7789_spi_rx;
  localparam int SYNC = 2;
  localparam int IDLE = 64;

  logic w_clk   = 1'b0;
  logic w_rst_n = 1'b0;
  always #5 w_clk = ~w_clk;

  st7789_spi_rx_if bus ();

  st7789_spi_rx #(.SYNC_STAGES(SYNC), .IDLE_CYC(IDLE)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_frames = 0;
  int   seen_frames = 0;
  int   wr_count = 0;

  // Reference model state
  int         m_mode;   // 0 idle, 1 parameter, 2 memory write
  int         m_tgt;    // 0 CASET, 1 RASET, 2 MADCTL, 3 COLMOD
  int         m_pidx;
  int         m_phase;
  int         m_n;      // pixels written since the last 0x2C
  logic [7:0] m_hi, m_xs, m_xe, m_ys, m_ye, m_mad, m_col;
  logic       m_disp, m_inv;

  function automatic void model_reset();
    m_mode = 0; m_tgt = 0; m_pidx = 0; m_phase = 0; m_n = 0; m_hi = 8'd0;
    m_xs = 8'd0; m_xe = 8'd239; m_ys = 8'd0; m_ye = 8'd239;
    m_mad = 8'd0; m_col = 8'd0; m_disp = 1'b0; m_inv = 1'b0;
  endfunction

  // Pixel n of a burst lands at column n mod W, row (n div W) mod H of the window.
  function automatic void push_pixel(input logic [15:0] pix);
    logic [7:0] dx, dy;
    int cols, rows, col, row;
    exp_t e;
    dx = m_xe - m_xs;
    dy = m_ye - m_ys;
    cols = int'(dx) + 1;
    rows = int'(dy) + 1;
    col = m_n % cols;
    row = (m_n / cols) % rows;
    e.a  = {8'(int'(m_ys) + row), 8'(int'(m_xs) + col)};
    e.d  = pix;
    e.fd = (col == cols - 1) && (row == rows - 1);
    if (e.fd) exp_frames++;
    exp_q.push_back(e);
    m_n++;
  endfunction

  function automatic void model_byte(input logic dc, input logic [7:0] b);
    if (!dc) begin
      m_pidx = 0; m_phase = 0; m_n = 0; m_mode = 0;
      case (b)
        8'h2A: begin m_mode = 1; m_tgt = 0; end
        8'h2B: begin m_mode = 1; m_tgt = 1; end
        8'h36: begin m_mode = 1; m_tgt = 2; end
        8'h3A: begin m_mode = 1; m_tgt = 3; end
        8'h2C: m_mode = 2;
        8'h21: m_inv = 1'b1;
        8'h20: m_inv = 1'b0;
        8'h29: m_disp = 1'b1;
        8'h28: m_disp = 1'b0;
        8'h01: model_reset();
        default: ;
      endcase
    end else if (m_mode == 1) begin
      if (m_tgt < 2) begin
        if (m_pidx == 1) begin if (m_tgt == 0) m_xs = b; else m_ys = b; end
        if (m_pidx == 3) begin if (m_tgt == 0) m_xe = b; else m_ye = b; end
        m_pidx++;
        if (m_pidx == 4) m_mode = 0;
      end else begin
        if (m_tgt == 2) m_mad = b; else m_col = b;
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (m_phase == 0) begin m_hi = b; m_phase = 1; end
      else begin m_phase = 0; push_pixel({m_hi, b}); end
    end
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Drive n bits MSB first: SDA changes with SCL rising, SCL low one cycle.
  task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge w_clk);
      bus.st7789_SCL = 1'b1;
      bus.st7789_SDA = b[7-i];
      bus.st7789_DC  = dc;
      @(negedge w_clk);
      bus.st7789_SCL = 1'b0;
    end
    @(negedge w_clk);
    bus.st7789_SCL = 1'b1;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    model_byte(dc, b);
    send_bits(dc, b, 8);
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send_byte(1'b1, p[15:8]);
    send_byte(1'b1, p[7:0]);
  endtask

  task automatic settle();
    repeat (SYNC + 4) @(negedge w_clk);
  endtask

  task automatic check_status(input string tag);
    settle();
    chk({tag, "_madctl"},  {8'd0, bus.w_madctl},  {8'd0, m_mad});
    chk({tag, "_colmod"},  {8'd0, bus.w_colmod},  {8'd0, m_col});
    chk({tag, "_disp_on"}, {15'd0, bus.w_disp_on}, {15'd0, m_disp});
    chk({tag, "_inv_on"},  {15'd0, bus.w_inv_on},  {15'd0, m_inv});
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [7:0] s, input logic [7:0] e);
    send_byte(1'b0, cmd);
    send_byte(1'b1, 8'($urandom));
    send_byte(1'b1, s);
    send_byte(1'b1, 8'($urandom));
    send_byte(1'b1, e);
  endtask

  // Scoreboard monitor: compares every write strobe with the next prediction.
  exp_t mon_e;
  always @(negedge w_clk) begin
    if (w_rst_n) begin
      if (bus.w_frame_done) seen_frames++;
      if (bus.w_we) begin
        wr_count++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%h data=%h required no write", bus.w_waddr, bus.w_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.w_waddr !== mon_e.a || bus.w_wdata !== mon_e.d || bus.w_frame_done !== mon_e.fd) begin
            bad++;
            $display("FAIL pixel_write: got addr=%h data=%h fd=%b required addr=%h data=%h fd=%b",
                     bus.w_waddr, bus.w_wdata, bus.w_frame_done, mon_e.a, mon_e.d, mon_e.fd);
          end
        end
      end else if (bus.w_frame_done) begin
        total++;
        bad++;
        $display("FAIL frame_done_alone: got frame_done=1 required 0 without w_we");
      end
    end
  end

  initial begin
    int f0, w0, n;
    logic [7:0] s, op;
    logic [15:0] p;
    bus.st7789_SCL = 1'b1;
    bus.st7789_SDA = 1'b1;
    bus.st7789_DC  = 1'b1;
    model_reset();
    repeat (3) @(negedge w_clk);
    w_rst_n = 1'b1;
    repeat (2) @(negedge w_clk);

    // Reset state
    chk("rst_we",     {15'd0, bus.w_we}, 16'd0);
    chk("rst_waddr",  bus.w_waddr, 16'd0);
    chk("rst_wdata",  bus.w_wdata, 16'd0);
    chk("rst_fdone",  {15'd0, bus.w_frame_done}, 16'd0);
    check_status("rst");

    // Init sequence: no writes, status as programmed
    send_byte(1'b0, 8'h01); send_byte(1'b0, 8'h11);
    send_byte(1'b0, 8'h3A); send_byte(1'b1, 8'h55);
    send_byte(1'b0, 8'h36); send_byte(1'b1, 8'h00);
    send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h13); send_byte(1'b0, 8'h29);
    check_status("init");
    chk("init_colmod_const", {8'd0, bus.w_colmod}, 16'h0055);
    chk("init_flags_const", {14'd0, bus.w_disp_on, bus.w_inv_on}, 16'h0003);
    chk("init_no_writes", 16'(wr_count), 16'd0);

    // Window 2..3 x 5..6 with wrap back to the start
    f0 = seen_frames;
    send_window(8'h2A, 8'h02, 8'h03);
    send_window(8'h2B, 8'h05, 8'h06);
    send_byte(1'b0, 8'h2C);
    for (int i = 1; i <= 5; i++) send_pixel(16'(i));
    settle();
    chk("wrap_last_addr", bus.w_waddr, 16'h0502);
    chk("wrap_last_data", bus.w_wdata, 16'h0005);
    chk("wrap_frames", 16'(seen_frames - f0), 16'd1);

    // Complete 16x16 frame ending at (0xEF, 0xEF)
    f0 = seen_frames;
    send_window(8'h2A, 8'hE0, 8'hEF);
    send_window(8'h2B, 8'hE0, 8'hEF);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 256; i++) send_pixel(16'($urandom));
    settle();
    chk("frame_last_addr", bus.w_waddr, 16'hEFEF);
    chk("frame_frames", 16'(seen_frames - f0), 16'd1);

    // Abort: half pixel then a command, restart at window origin
    w0 = wr_count;
    send_byte(1'b0, 8'h2C); send_byte(1'b1, 8'hF8); send_byte(1'b0, 8'h2A);
    send_byte(1'b0, 8'h2C); send_pixel(16'h1234);
    settle();
    chk("abort_writes", 16'(wr_count - w0), 16'd1);
    chk("abort_addr", bus.w_waddr, 16'hE0E0);
    chk("abort_data", bus.w_wdata, 16'h1234);

    // Randomised command/data mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0: begin s = 8'($urandom); send_window(8'h2A, s, s + 8'($urandom_range(0, 5))); end
        1: begin s = 8'($urandom); send_window(8'h2B, s, s + 8'($urandom_range(0, 5))); end
        2: begin send_byte(1'b0, 8'h36); send_byte(1'b1, 8'($urandom)); end
        3: begin send_byte(1'b0, 8'h3A); send_byte(1'b1, 8'($urandom)); end
        4: begin op = 8'h20 | 8'($urandom_range(0, 1)) | (8'($urandom_range(0, 1)) << 3); send_byte(1'b0, op); end
        5: send_byte(1'b0, 8'($urandom));
        6, 7: begin
          send_byte(1'b0, 8'h2C);
          n = $urandom_range(0, 30);
          for (int k = 0; k < n; k++) send_pixel(16'($urandom));
          if ($urandom_range(0, 1) == 1) send_byte(1'b1, 8'($urandom));
        end
        8: begin send_byte(1'b1, 8'($urandom)); send_byte(1'b1, 8'($urandom)); end
        default: send_byte(1'b0, 8'h01);
      endcase
      check_status("rand");
    end

    // Resync: three stray bits, idle, then a full command
    send_byte(1'b0, 8'h28);
    send_bits(1'b1, 8'hA5, 3);
    repeat (IDLE + 8) @(negedge w_clk);
    send_byte(1'b0, 8'h29);
    check_status("resync_on");
    chk("resync_on_const", {15'd0, bus.w_disp_on}, 16'd1);
    send_byte(1'b0, 8'h28);
    check_status("resync_off");
    chk("resync_off_const", {15'd0, bus.w_disp_on}, 16'd0);

    // Reset mid-pixel after 12 bits
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAB);
    send_bits(1'b1, 8'hCD, 4);
    @(negedge w_clk);
    w_rst_n = 1'b0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge w_clk);
    chk("rst2_we",    {15'd0, bus.w_we}, 16'd0);
    chk("rst2_waddr", bus.w_waddr, 16'd0);
    chk("rst2_wdata", bus.w_wdata, 16'd0);
    check_status("rst2");
    send_byte(1'b0, 8'h2C);
    p = 16'($urandom);
    send_pixel(p);
    settle();
    chk("rst2_first_addr", bus.w_waddr, 16'h0000);
    chk("rst2_first_data", bus.w_wdata, p);

    repeat (10) @(negedge w_clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    chk("frame_count", 16'(seen_frames), 16'(exp_frames));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
